// File: rtl/rlug_pkg.sv
// rtl/rlug_pkg.sv - shared types and helpers for the NAND trial sequencer
// Purpose: sequencer state encoding, golden NAND function, bundle popcount.
// Ports: none (package).
package rlug_pkg;

    // Widest bundle the popcount helper handles; callers zero-extend into it.
    localparam int MAX_BUNDLE_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } seq_state_t;

    function automatic logic golden_nand(input logic x, input logic y);
        return ~(x & y);
    endfunction

    function automatic logic [5:0] popcount(input logic [MAX_BUNDLE_W-1:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < MAX_BUNDLE_W; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/nand_majority_voter.sv
// rtl/nand_majority_voter.sv - combinational bundle-vs-golden comparator and majority vote
// Purpose: count gates disagreeing with golden, and flag a wrong majority decision.
// Ports:
//   z_i            in   BUNDLE_WIDTH  gate outputs
//   golden_i       in   1             expected NAND result
//   mismatch_cnt_o out  CNT_W         number of gates with z != golden
//   vote_err_o     out  1             majority(z) != golden
module nand_majority_voter
    import rlug_pkg::*;
#(
    parameter  int BUNDLE_WIDTH = 5,
    localparam int CNT_W        = $clog2(BUNDLE_WIDTH + 1)
) (
    input  logic [BUNDLE_WIDTH-1:0] z_i,
    input  logic                    golden_i,
    output logic [CNT_W-1:0]        mismatch_cnt_o,
    output logic                    vote_err_o
);

    logic [5:0] mis_pc;
    logic [5:0] ones_pc;
    logic       majority;

    assign mis_pc         = popcount(MAX_BUNDLE_W'(z_i ^ {BUNDLE_WIDTH{golden_i}}));
    assign ones_pc        = popcount(MAX_BUNDLE_W'(z_i));
    assign mismatch_cnt_o = mis_pc[CNT_W-1:0];
    // BUNDLE_WIDTH is odd, so strict majority never ties.
    assign majority       = ones_pc > 6'(BUNDLE_WIDTH / 2);
    assign vote_err_o     = majority != golden_i;

endmodule

// File: rtl/nand_trial_sequencer.sv
// rtl/nand_trial_sequencer.sv - campaign controller for a redundant erroneous NAND bundle
// Purpose: drive one 2-bit vector per trial to every gate, capture the bundle one cycle
//   later, and accumulate per-gate and post-vote error counts (saturating).
// Ports:
//   clk, reset_n      clock, async active-low reset
//   start_i           start campaign (sampled only in IDLE)
//   num_trials_i      trial count, latched on accepted start
//   x_o, y_o          replicated gate inputs (registered)
//   z_i               registered gate outputs
//   busy_o, done_o    campaign running / one-cycle completion pulse
//   trials_done_o     completed trials
//   gate_err_cnt_o    sum of per-gate mismatches
//   vote_err_cnt_o    trials with a wrong majority
module nand_trial_sequencer
    import rlug_pkg::*;
#(
    parameter int BUNDLE_WIDTH = 5,
    parameter int TRIAL_CNT_W  = 16,
    parameter int ERR_CNT_W    = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start_i,
    input  logic [TRIAL_CNT_W-1:0]  num_trials_i,
    output logic [BUNDLE_WIDTH-1:0] x_o,
    output logic [BUNDLE_WIDTH-1:0] y_o,
    input  logic [BUNDLE_WIDTH-1:0] z_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [TRIAL_CNT_W-1:0]  trials_done_o,
    output logic [ERR_CNT_W-1:0]    gate_err_cnt_o,
    output logic [ERR_CNT_W-1:0]    vote_err_cnt_o
);

    localparam int                   CNT_W   = $clog2(BUNDLE_WIDTH + 1);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

    seq_state_t              state_q, state_d;
    logic [TRIAL_CNT_W-1:0]  num_trials_q, num_trials_d;
    logic [TRIAL_CNT_W-1:0]  trials_q, trials_d;
    logic [ERR_CNT_W-1:0]    gate_err_q, gate_err_d;
    logic [ERR_CNT_W-1:0]    vote_err_q, vote_err_d;
    logic [BUNDLE_WIDTH-1:0] x_q, x_d, y_q, y_d;

    logic                    golden;
    logic [CNT_W-1:0]        mismatch_cnt;
    logic                    vote_err;
    logic [TRIAL_CNT_W-1:0]  trials_inc;
    logic [ERR_CNT_W:0]      gate_sum;

    // All bits of the held vector are identical, so bit 0 carries the trial vector.
    assign golden     = golden_nand(x_q[0], y_q[0]);
    assign trials_inc = trials_q + 1'b1;
    // One guard bit is enough: a single trial adds at most BUNDLE_WIDTH.
    assign gate_sum   = {1'b0, gate_err_q} + (ERR_CNT_W + 1)'(mismatch_cnt);

    nand_majority_voter #(.BUNDLE_WIDTH(BUNDLE_WIDTH)) u_voter (
        .z_i            (z_i),
        .golden_i       (golden),
        .mismatch_cnt_o (mismatch_cnt),
        .vote_err_o     (vote_err)
    );

    always_comb begin
        state_d      = state_q;
        num_trials_d = num_trials_q;
        trials_d     = trials_q;
        gate_err_d   = gate_err_q;
        vote_err_d   = vote_err_q;
        x_d          = x_q;
        y_d          = y_q;
        case (state_q)
            IDLE: begin
                x_d = '0;
                y_d = '0;
                if (start_i) begin
                    num_trials_d = num_trials_i;
                    trials_d     = '0;
                    gate_err_d   = '0;
                    vote_err_d   = '0;
                    // Trial 0 vector is 00, which is already on x/y.
                    state_d      = (num_trials_i == '0) ? DONE : DRIVE;
                end
            end
            DRIVE: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                trials_d   = trials_inc;
                gate_err_d = gate_sum[ERR_CNT_W] ? ERR_MAX : gate_sum[ERR_CNT_W-1:0];
                if (vote_err && vote_err_q != ERR_MAX) begin
                    vote_err_d = vote_err_q + 1'b1;
                end
                if (trials_inc == num_trials_q) begin
                    state_d = DONE;
                    x_d     = '0;
                    y_d     = '0;
                end else begin
                    state_d = DRIVE;
                    x_d     = {BUNDLE_WIDTH{trials_inc[1]}};
                    y_d     = {BUNDLE_WIDTH{trials_inc[0]}};
                end
            end
            DONE: begin
                state_d = IDLE;
                x_d     = '0;
                y_d     = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            num_trials_q <= '0;
            trials_q     <= '0;
            gate_err_q   <= '0;
            vote_err_q   <= '0;
            x_q          <= '0;
            y_q          <= '0;
        end else begin
            state_q      <= state_d;
            num_trials_q <= num_trials_d;
            trials_q     <= trials_d;
            gate_err_q   <= gate_err_d;
            vote_err_q   <= vote_err_d;
            x_q          <= x_d;
            y_q          <= y_d;
        end
    end

    assign x_o            = x_q;
    assign y_o            = y_q;
    assign busy_o         = state_q != IDLE;
    assign done_o         = state_q == DONE;
    assign trials_done_o  = trials_q;
    assign gate_err_cnt_o = gate_err_q;
    assign vote_err_cnt_o = vote_err_q;

endmodule
